// File: rtl/key_shift_led_ctrl.sv
// Three debounced push-buttons drive an LED pattern in ROTATE, BOUNCE or FILL mode.
// The press event reaches the LED register DB_CYCLES+2 edges after the first low sample.

module key_shift_led_ctrl_db #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_key,
   output logic o_press
);
   localparam int CW = $clog2(DB_CYCLES);

   logic          r_sync1, r_sync2, r_stable, r_press;
   logic [CW-1:0] r_cnt;

   // The press flag is set on the same edge that stable falls, so it is high for the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b1;
         r_press  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_key;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DB_CYCLES - 1)) begin
            r_cnt    <= '0;
            r_stable <= r_sync2;
            r_press  <= ~r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_press = r_press;
endmodule

module key_shift_led_ctrl #(
   parameter int N_LED     = 4,
   parameter int DB_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_fwd,
   input  logic             key_bwd,
   input  logic             key_mode,
   output logic [N_LED-1:0] led,
   output logic [1:0]       mode
);
   localparam int KW = $clog2(N_LED + 1);

   typedef enum logic [1:0] {
      ROTATE = 2'd0,
      BOUNCE = 2'd1,
      FILL   = 2'd2
   } mode_t;

   logic [2:0]       w_keys, w_evt;
   logic             w_evt_fwd, w_evt_bwd, w_evt_mode;
   mode_t            r_mode, w_mode_nx;
   logic [N_LED-1:0] r_led, w_led_nx, w_bounce;
   logic [KW-1:0]    r_k, w_k_nx;
   logic             r_dir_up, w_up_nx, w_go_up;

   assign w_keys = {key_mode, key_bwd, key_fwd};

   for (genvar g = 0; g < 3; g++) begin : g_db
      key_shift_led_ctrl_db #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_key  (w_keys[g]),
         .o_press(w_evt[g])
      );
   end

   assign w_evt_fwd  = w_evt[0];
   assign w_evt_bwd  = w_evt[1];
   assign w_evt_mode = w_evt[2];

   function automatic logic [N_LED-1:0] therm(input logic [KW-1:0] k);
      logic [N_LED-1:0] t;
      t = '0;
      for (int i = 0; i < N_LED; i++) t[i] = (i < int'(k));
      return t;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode   <= ROTATE;
         r_led    <= N_LED'(1);
         r_k      <= KW'(1);
         r_dir_up <= 1'b1;
      end else begin
         r_mode   <= w_mode_nx;
         r_led    <= w_led_nx;
         r_k      <= w_k_nx;
         r_dir_up <= w_up_nx;
      end
   end

   // A bounce step sitting on the end it is heading towards turns back rather than dropping the bit.
   always_comb begin
      w_mode_nx = r_mode;
      w_led_nx  = r_led;
      w_k_nx    = r_k;
      w_up_nx   = r_dir_up;
      w_go_up   = r_dir_up ? ~r_led[N_LED-1] : r_led[0];
      w_bounce  = w_go_up ? (r_led << 1) : (r_led >> 1);
      if (w_evt_mode) begin
         case (r_mode)
            ROTATE:  w_mode_nx = BOUNCE;
            BOUNCE:  w_mode_nx = FILL;
            default: w_mode_nx = ROTATE;
         endcase
         w_led_nx = N_LED'(1);
         w_k_nx   = KW'(1);
         w_up_nx  = 1'b1;
      end else if (w_evt_fwd ^ w_evt_bwd) begin
         case (r_mode)
            ROTATE: begin
               if (w_evt_fwd) w_led_nx = {r_led[N_LED-2:0], r_led[N_LED-1]};
               else           w_led_nx = {r_led[0], r_led[N_LED-1:1]};
            end
            BOUNCE: begin
               if (w_evt_fwd) begin
                  w_led_nx = w_bounce;
                  w_up_nx  = w_go_up ? ~w_bounce[N_LED-1] : w_bounce[0];
               end else begin
                  w_up_nx  = ~r_dir_up;
               end
            end
            default: begin
               if (w_evt_fwd) w_k_nx = (r_k == KW'(N_LED)) ? '0 : r_k + 1'b1;
               else           w_k_nx = (r_k == '0) ? KW'(N_LED) : r_k - 1'b1;
               w_led_nx = therm(w_k_nx);
            end
         endcase
      end
   end

   assign led  = r_led;
   assign mode = r_mode;
endmodule

// File: tb/tb_key_shift_led_ctrl.sv
// Directed bench for key_shift_led_ctrl: per-cycle compare against a position/count model
// plus literal expectations at the interesting points.

module tb_key_shift_led_ctrl;
   localparam int N  = 4;
   localparam int DB = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         key_fwd = 1'b1, key_bwd = 1'b1, key_mode = 1'b1;
   logic [N-1:0] led;
   logic [1:0]   mode;

   int errors = 0;
   int checks = 0;

   key_shift_led_ctrl #(.N_LED(N), .DB_CYCLES(DB)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .key_fwd (key_fwd),
      .key_bwd (key_bwd),
      .key_mode(key_mode),
      .led     (led),
      .mode    (mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: mode number, lit position (ROTATE/BOUNCE), fill count, bounce direction.
   int m_mode = 0, m_pos = 0, m_k = 1;
   bit m_up = 1'b1;
   int lag0[3], lag1[3], st[3], cnt[3], ev[3];

   function automatic logic [N-1:0] exp_led();
      if (m_mode == 2) return N'((1 << m_k) - 1);
      return N'(1 << m_pos);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_k = 1; m_up = 1'b1;
      for (int i = 0; i < 3; i++) begin
         lag0[i] = 1; lag1[i] = 1; st[i] = 1; cnt[i] = 0; ev[i] = 0;
      end
   endtask

   task automatic model_step();
      int raw[3];
      bit go_up;
      raw[0] = int'(key_fwd); raw[1] = int'(key_bwd); raw[2] = int'(key_mode);
      if (ev[2] != 0) begin
         m_mode = (m_mode + 1) % 3; m_pos = 0; m_k = 1; m_up = 1'b1;
      end else if ((ev[0] != 0) != (ev[1] != 0)) begin
         if (m_mode == 0) begin
            m_pos = (ev[0] != 0) ? (m_pos + 1) % N : (m_pos + N - 1) % N;
         end else if (m_mode == 1) begin
            if (ev[0] != 0) begin
               go_up = m_up ? (m_pos != N - 1) : (m_pos == 0);
               m_pos = go_up ? m_pos + 1 : m_pos - 1;
               m_up  = go_up ? (m_pos != N - 1) : (m_pos == 0);
            end else begin
               m_up = ~m_up;
            end
         end else begin
            m_k = (ev[0] != 0) ? (m_k == N ? 0 : m_k + 1) : (m_k == 0 ? N : m_k - 1);
         end
      end
      // Each debouncer sees the raw sample from two edges back.
      for (int i = 0; i < 3; i++) begin
         int x;
         x = lag1[i]; lag1[i] = lag0[i]; lag0[i] = raw[i]; ev[i] = 0;
         if (x != st[i]) begin
            cnt[i]++;
            if (cnt[i] == DB) begin
               st[i] = x; cnt[i] = 0; ev[i] = (x == 0) ? 1 : 0;
            end
         end else begin
            cnt[i] = 0;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         chk("led_model", 32'(led), 32'(exp_led()));
         chk("mode_model", 32'(mode), 32'(m_mode));
      end else begin
         chk("led_in_reset", 32'(led), 32'd1);
         chk("mode_in_reset", 32'(mode), 32'd0);
      end
   end

   task automatic press(input logic f, input logic b, input logic md, input int len);
      @(posedge clk); #3;
      key_fwd = ~f; key_bwd = ~b; key_mode = ~md;
      repeat (len) @(posedge clk);
      #3 key_fwd = 1'b1; key_bwd = 1'b1; key_mode = 1'b1;
      repeat (DB + 8) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 chk("reset_led", 32'(led), 32'h1);
      chk("reset_mode", 32'(mode), 32'h0);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Held key: exactly one step at edge DB+2, nothing more while held
      @(posedge clk); #3 key_fwd = 1'b0;
      repeat (6) @(posedge clk);
      #1 chk("lat_edge5", 32'(led), 32'b0001);
      @(posedge clk);
      #1 chk("lat_edge6", 32'(led), 32'b0010);
      repeat (13) @(posedge clk);
      #1 chk("held_no_repeat", 32'(led), 32'b0010);
      #2 key_fwd = 1'b1;
      repeat (12) @(posedge clk);

      // Glitch and ROTATE
      press(1, 0, 0, 3); chk("glitch", 32'(led), 32'b0010);
      press(0, 1, 0, 6); chk("rot_bwd1", 32'(led), 32'b0001);
      press(0, 1, 0, 6); chk("rot_bwd_wrap", 32'(led), 32'b1000);
      press(1, 0, 0, 6); chk("rot_fwd_wrap", 32'(led), 32'b0001);

      // BOUNCE
      press(0, 0, 1, 6); chk("bnc_mode", 32'(mode), 32'd1); chk("bnc_led0", 32'(led), 32'b0001);
      press(1, 0, 0, 6); chk("bnc_f1", 32'(led), 32'b0010);
      press(1, 0, 0, 6); chk("bnc_f2", 32'(led), 32'b0100);
      press(1, 0, 0, 6); chk("bnc_f3", 32'(led), 32'b1000);
      press(1, 0, 0, 6); chk("bnc_f4", 32'(led), 32'b0100);
      press(0, 1, 0, 6); chk("bnc_bwd", 32'(led), 32'b0100);
      press(1, 0, 0, 6); chk("bnc_f5", 32'(led), 32'b1000);

      // FILL
      press(0, 0, 1, 6); chk("fill_mode", 32'(mode), 32'd2); chk("fill_led0", 32'(led), 32'b0001);
      press(1, 0, 0, 6); chk("fill_f1", 32'(led), 32'b0011);
      press(1, 0, 0, 6); chk("fill_f2", 32'(led), 32'b0111);
      press(1, 0, 0, 6); chk("fill_f3", 32'(led), 32'b1111);
      press(1, 0, 0, 6); chk("fill_f4_wrap", 32'(led), 32'b0000);
      press(0, 1, 0, 6); chk("fill_bwd_wrap", 32'(led), 32'b1111);

      // Simultaneous events
      press(0, 0, 1, 6); chk("mode_wrap", 32'(mode), 32'd0); chk("mode_wrap_led", 32'(led), 32'b0001);
      press(1, 0, 0, 6); chk("rot_f", 32'(led), 32'b0010);
      press(1, 1, 0, 6); chk("fwd_bwd_same", 32'(led), 32'b0010);
      press(1, 0, 1, 6); chk("mode_prio_mode", 32'(mode), 32'd1); chk("mode_prio_led", 32'(led), 32'b0001);
      press(1, 0, 0, 6); chk("bnc_again", 32'(led), 32'b0010);

      // Reset mid-debounce
      @(posedge clk); #3 key_fwd = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("rst_mid_led", 32'(led), 32'b0001);
      chk("rst_mid_mode", 32'(mode), 32'd0);
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("post_rst_edge5", 32'(led), 32'b0001);
      @(posedge clk);
      #1 chk("post_rst_edge6", 32'(led), 32'b0010);
      #2 key_fwd = 1'b1;
      repeat (12) @(posedge clk);
      #1 chk("post_rst_final", 32'(led), 32'b0010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/key_shift_led_ctrl.md
KEY_SHIFT_LED_CTRL -- requirements
Module: key_shift_led_ctrl

Interface
REQ-001 SHALL have parameter N_LED, default 4, number of LED outputs; legal range 2..32.
REQ-002 SHALL have parameter DB_CYCLES, default 1000000, debounce length in clk cycles; legal minimum 2.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port key_fwd  input  1  asynchronous push-button, active-low; 1 = released.
REQ-006 SHALL have port key_bwd  input  1  asynchronous push-button, active-low.
REQ-007 SHALL have port key_mode  input  1  asynchronous push-button, active-low.
REQ-008 SHALL have port led  output  N_LED  registered LED pattern, 1 = lit.
REQ-009 SHALL have port mode  output  2  registered mode: 0 ROTATE, 1 BOUNCE, 2 FILL; value 3 never driven.

Function
REQ-010 SHALL pass each key through a 2-flop synchroniser (sync1, sync2), both resetting to 1.
REQ-011 SHALL debounce each key independently: a stable register updates only after sync2 differs from stable for DB_CYCLES consecutive cycles; any cycle with sync2 equal to stable clears that key's counter.
REQ-012 SHALL produce a one-cycle press event per key in the cycle after that key's stable register goes 1->0; a stable 0->1 transition (release) SHALL produce no event.
REQ-013 SHALL give a key held low indefinitely exactly one press event.
REQ-014 SHALL update led/mode at the edge ending the event cycle; total latency is input low first sampled at edge 0 -> led/mode change at edge DB_CYCLES+2.
REQ-015 SHALL advance mode on a key_mode event: 0->1->2->0.
REQ-016 SHALL, on any mode change, set led to bit0 only (led=1), FILL count to 1, and BOUNCE direction to up.
REQ-017 SHALL give a key_mode event priority: simultaneous fwd/bwd events in that cycle are discarded.
REQ-018 SHALL leave led unchanged when fwd and bwd events occur in the same cycle with no mode event.
REQ-019 SHALL, in ROTATE, rotate led left by one on fwd (led[N_LED-1] wraps into bit0) and right by one on bwd (bit0 wraps into led[N_LED-1]).
REQ-020 SHALL, in BOUNCE, move the single lit bit one position in the current direction on fwd; on reaching bit N_LED-1 (up) or bit0 (down), the direction SHALL invert in that same update so the next fwd moves back.
REQ-021 SHALL, in BOUNCE, invert the direction on bwd without moving led.
REQ-022 SHALL, in FILL, hold count k in 0..N_LED, with led = lowest k bits set (thermometer code).
REQ-023 SHALL, in FILL, make fwd k+1, wrapping N_LED->0.
REQ-024 SHALL, in FILL, make bwd k-1, wrapping 0->N_LED.
REQ-025 SHALL keep exactly one bit lit at all times in ROTATE and BOUNCE.
REQ-026 SHALL derive every counter width from its parameter so no counter overflows at maximum legal values.

Reset
REQ-027 SHALL, while rst_n=0, force sync1/sync2/stable=1, debounce counters=0, events=0, mode=0, led=1 (bit0 only), FILL k=1, direction up.
REQ-028 SHALL treat rst_n assertion mid-debounce or mid-press as aborting it: no event after release of reset unless the key stays low a full DB_CYCLES again.
REQ-029 SHALL generate no event from a key already held low at reset release until DB_CYCLES cycles of low have been counted after release.

Verification (N_LED=4, DB_CYCLES=4)
REQ-030 SHALL cover: reset -> led=0001, mode=0; key_fwd low 20 cycles -> led=0010 exactly at edge 6 after first low sample, no further change while held.
REQ-031 SHALL cover: key_fwd low 3 cycles then high (glitch) -> no led change; ROTATE bwd from 0001 -> 1000.
REQ-032 SHALL cover: one key_mode press -> mode=1, led=0001; fwd x4 -> 0010, 0100, 1000, 0100; then bwd, fwd -> 1000.
REQ-033 SHALL cover: two key_mode presses -> mode=2, led=0001; fwd x4 -> 0011, 0111, 1111, 0000; bwd -> 1111.
REQ-034 SHALL cover: fwd and bwd pressed on the same cycle -> led unchanged; key_mode with fwd on the same cycle -> mode advances, led=0001.
REQ-035 SHALL cover: rst_n pulsed low while key_fwd low 2 cycles into debounce -> led=0001 after reset, and led=0010 only after 4 further low cycles plus latency.
